uart_program_loader: RTL and testbench

- Upstream feeder for the CPU instruction-write port. Replaces the hard-coded instruction case table in the board top.
- Receives a framed program image over a UART RX pin and assembles byte pairs into 16-bit Thumb halfwords, low byte first.
- Issues one write per halfword to CPU instruction memory and holds the CPU in download mode until the image is accepted.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/uart_rx.sv | 101 ++++++++++
 rtl/uart_program_loader.sv | 173 +++++++++++++++++
 tb/tb_uart_program_loader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    GET_COUNT,
    GET_LO,
    GET_HI,
    WRITE,
    GET_CSUM,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  // Word counter width; the index space is 8-bit so a frame never needs more.
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, glitch-rejecting start
// detection, one-cycle byte_valid or frame_err pulse per character.
module uart_rx
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] BIT_LAST  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]        r_sync;
  logic              r_rx_d;
  rx_state_t         r_state;
  logic [TICK_W-1:0] r_tick;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_byte_valid;
  logic [7:0]        r_byte_data;
  logic              r_frame_err;
  logic              w_rx;

  assign w_rx       = r_sync[1];
  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign frame_err  = r_frame_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync       <= 2'b11;
      r_rx_d       <= 1'b1;
      r_state      <= RX_IDLE;
      r_tick       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sync       <= {r_sync[0], rx};
      r_rx_d       <= w_rx;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_rx_d && !w_rx) begin
            r_state <= RX_START;
            r_tick  <= '0;
          end
        end
        // Re-check the line at mid-start; a high here was only a glitch.
        RX_START: begin
          if (r_tick == HALF_LAST) begin
            r_tick  <= '0;
            r_bit   <= '0;
            r_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        RX_DATA: begin
          if (r_tick == BIT_LAST) begin
            r_tick  <= '0;
            r_shift <= {w_rx, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= RX_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        RX_STOP: begin
          if (r_tick == BIT_LAST) begin
            r_tick  <= '0;
            r_state <= RX_IDLE;
            if (w_rx) begin
              r_byte_valid <= 1'b1;
              r_byte_data  <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_tick <= r_tick + TICK_W'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Receives a framed program image over UART and writes it as 16-bit halfwords to
// CPU instruction memory. Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned START_INDEX  = 10,
  parameter int unsigned MAX_WORDS    = 246,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        download,
  output logic        wr_en,
  output logic [7:0]  wr_index,
  output logic [15:0] wr_data,
  output logic        done,
  output logic        error
);

  if (START_INDEX + MAX_WORDS > 256) begin : g_bad_range
    $error("uart_program_loader: START_INDEX + MAX_WORDS exceeds 256");
  end
  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("uart_program_loader: CLKS_PER_BIT must be >= 4");
  end

  logic             w_bv;
  logic [7:0]       w_byte;
  logic             w_fe;
  logic             w_bad_count;
  logic             w_to_err;
  logic [CNT_W-1:0] w_cnt_nxt;

  loader_state_t    r_state;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_lo;
  logic             r_download;
  logic             r_wr_en;
  logic [7:0]       r_wr_index;
  logic [15:0]      r_wr_data;
  logic             r_done;
  logic             r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (uart_rx),
    .byte_valid(w_bv),
    .byte_data (w_byte),
    .frame_err (w_fe)
  );

  assign download    = r_download;
  assign wr_en       = r_wr_en;
  assign wr_index    = r_wr_index;
  assign wr_data     = r_wr_data;
  assign done        = r_done;
  assign error       = r_error;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_bad_count = w_bv && ((w_byte == 8'd0) || ({1'b0, w_byte} > 9'(MAX_WORDS)));

  // Conditions that abort the current frame; framing errors are ignored while idle.
  always_comb begin
    w_to_err = 1'b0;
    case (r_state)
      GET_COUNT:      w_to_err = w_fe || w_bad_count;
      GET_LO, GET_HI: w_to_err = w_fe;
`ifdef LOADER_CHECKSUM_EN
      GET_CSUM:       w_to_err = w_fe || (w_bv && (w_byte != r_csum));
`endif
      default:        w_to_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= WAIT_SYNC;
      r_n        <= '0;
      r_cnt      <= '0;
      r_lo       <= '0;
      r_download <= 1'b1;
      r_wr_en    <= 1'b0;
      r_wr_index <= 8'(START_INDEX);
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (w_to_err) begin
        r_state    <= ERROR;
        r_error    <= 1'b1;
        r_download <= 1'b1;
      end else begin
        case (r_state)
          // A sync byte (re)starts a frame and re-asserts the CPU hold immediately.
          WAIT_SYNC, DONE, ERROR: begin
            if (w_bv && (w_byte == SYNC_BYTE)) begin
              r_state    <= GET_COUNT;
              r_download <= 1'b1;
              r_done     <= 1'b0;
              r_error    <= 1'b0;
            end
          end
          GET_COUNT: begin
            if (w_bv) begin
              r_n     <= w_byte;
              r_cnt   <= '0;
              r_state <= GET_LO;
`ifdef LOADER_CHECKSUM_EN
              r_csum  <= '0;
`endif
            end
          end
          GET_LO: begin
            if (w_bv) begin
              r_lo    <= w_byte;
              r_state <= GET_HI;
            end
          end
          GET_HI: begin
            if (w_bv) begin
              r_wr_en    <= 1'b1;
              r_wr_index <= 8'(START_INDEX) + r_cnt;
              r_wr_data  <= {w_byte, r_lo};
              r_state    <= WRITE;
            end
          end
          WRITE: begin
            r_cnt <= w_cnt_nxt;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ r_wr_data[15:8] ^ r_wr_data[7:0];
            if (w_cnt_nxt < r_n) begin
              r_state <= GET_LO;
            end else begin
              r_state <= GET_CSUM;
            end
`else
            if (w_cnt_nxt < r_n) begin
              r_state <= GET_LO;
            end else begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_download <= 1'b0;
            end
`endif
          end
`ifdef LOADER_CHECKSUM_EN
          GET_CSUM: begin
            if (w_bv) begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_download <= 1'b0;
            end
          end
`endif
          default: r_state <= WAIT_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader; follows LOADER_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_uart_program_loader;

  localparam int unsigned CPB = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        download;
  logic        wr_en;
  logic [7:0]  wr_index;
  logic [15:0] wr_data;
  logic        done;
  logic        error;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  logic [15:0] img[$];
  logic [23:0] mon_e;

  always #5 clk = ~clk;

  uart_program_loader #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (rx),
    .download(download),
    .wr_en   (wr_en),
    .wr_index(wr_index),
    .wr_data (wr_data),
    .done    (done),
    .error   (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected (index, data).
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_index_data", {8'h00, wr_index, wr_data}, {8'h00, mon_e});
      end
    end
  end

  task automatic bit_out(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
    bit_out(1'b1);
  endtask

  task automatic send_img(input logic [7:0] cnt);
    send_byte(8'hA5, 1'b1);
    send_byte(cnt, 1'b1);
    for (int i = 0; i < img.size(); i++) begin
      exp_q.push_back({8'(10 + i), img[i]});
      send_byte(img[i][7:0], 1'b1);
      send_byte(img[i][15:8], 1'b1);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  function automatic logic [7:0] img_csum();
    logic [7:0] c = 8'h00;
    for (int i = 0; i < img.size(); i++) c = c ^ img[i][7:0] ^ img[i][15:8];
    return c;
  endfunction
`endif

  task automatic expect_flags(input string tag, input logic d, input logic e, input logic dl);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_error"}, 32'(error), 32'(e));
    check({tag, "_download"}, 32'(download), 32'(dl));
    check({tag, "_no_pending_wr"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (4) @(negedge clk);
    expect_flags("reset", 1'b0, 1'b0, 1'b1);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_index", 32'(wr_index), 32'd10);
    check("reset_wr_data", 32'(wr_data), 32'd0);
    rst_n = 1'b1;
    repeat (4 * CPB) @(negedge clk);

    // Two-word image
    img = '{16'h2021, 16'h0022};
    send_img(8'd2);
`ifdef LOADER_CHECKSUM_EN
    check("csum_model", 32'(img_csum()), 32'h23);
    send_byte(img_csum(), 1'b1);
`endif
    expect_flags("img2", 1'b1, 1'b0, 1'b0);
    check("img2_hold_index", 32'(wr_index), 32'd11);
    check("img2_hold_data", 32'(wr_data), 32'h0022);

`ifdef LOADER_CHECKSUM_EN
    // Bad checksum: the write still happens, then error
    img = '{16'hFEE7};
    send_img(8'd1);
    send_byte(8'h00, 1'b1);
    expect_flags("bad_csum", 1'b0, 1'b1, 1'b1);
    send_img(8'd1);
    send_byte(img_csum(), 1'b1);
    expect_flags("recover_csum", 1'b1, 1'b0, 1'b0);
`else
    img = '{16'hFEE7};
    send_img(8'd1);
    expect_flags("one_word", 1'b1, 1'b0, 1'b0);
    check("one_word_hold_data", 32'(wr_data), 32'hFEE7);
`endif

    // Sync from DONE re-asserts download and clears done
    send_byte(8'hA5, 1'b1);
    expect_flags("resync", 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b1);
    expect_flags("count_zero", 1'b0, 1'b1, 1'b1);

    img = '{16'h1234};
    send_img(8'd1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(img_csum(), 1'b1);
`endif
    expect_flags("recover1", 1'b1, 1'b0, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'hF7, 1'b1);
    expect_flags("count_247", 1'b0, 1'b1, 1'b1);

    // Framing error on the lo byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hE7, 1'b0);
    expect_flags("frame_err", 1'b0, 1'b1, 1'b1);

    // Quarter-bit glitch between count and payload must not produce a byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    expect_flags("glitch", 1'b0, 1'b0, 1'b1);
    exp_q.push_back({8'd10, 16'hFEE7});
    send_byte(8'hE7, 1'b1);
    send_byte(8'hFE, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h19, 1'b1);
`endif
    expect_flags("after_glitch", 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-payload
    img = '{16'hBEEF, 16'hCAFE};
    send_img(8'd3);
    check("pre_reset_index", 32'(wr_index), 32'd11);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wr_index", 32'(wr_index), 32'd10);
    check("async_rst_wr_data", 32'(wr_data), 32'd0);
    check("async_rst_wr_en", 32'(wr_en), 32'd0);
    expect_flags("async_rst", 1'b0, 1'b0, 1'b1);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    img = '{16'h4711};
    send_img(8'd1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(img_csum(), 1'b1);
`endif
    expect_flags("post_reset", 1'b1, 1'b0, 1'b0);
    check("post_reset_data", 32'(wr_data), 32'h4711);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
